motor_ctrl_mc: RTL

Multi-channel successor to the single-channel motor controller: NUM_CH independent PWM generators and NUM_CH encoder speed counters behind one AXI4-Lite slave, all in one clock domain. Each channel has glitch-free PWM period/duty updates through shadow registers, polarity control and per-channel enable. A shared gate timer latches every channel's encoder edge count as its speed. The block sits between the processor's AXI interconnect and the motor driver/encoder pins.

---
 rtl/motor_ctrl_mc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/motor_ctrl_mc.sv
// rtl/motor_ctrl_mc.sv - multi-channel PWM generator and encoder speed meter behind an AXI4-Lite slave
module motor_ctrl_mc #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int ADDR_W      = 6,
    parameter int GATE_CYCLES = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [ADDR_W-1:0]    s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    input  logic [NUM_CH-1:0]    encoder_signal,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic [NUM_CH*32-1:0] motor_speed,
    output logic                 speed_valid
);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);

    logic [CNT_W-1:0]       period_sh_q [NUM_CH], period_sh_d [NUM_CH];
    logic [CNT_W-1:0]       duty_sh_q [NUM_CH], duty_sh_d [NUM_CH];
    logic [CNT_W-1:0]       period_act_q [NUM_CH], period_act_d [NUM_CH];
    logic [CNT_W-1:0]       duty_act_q [NUM_CH], duty_act_d [NUM_CH];
    logic [CNT_W-1:0]       cnt_q [NUM_CH], cnt_d [NUM_CH];
    logic [1:0]             ctrl_q [NUM_CH], ctrl_d [NUM_CH];
    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [NUM_CH-1:0]      enc_prev_q;
    logic [31:0]            edge_cnt_q [NUM_CH], edge_inc [NUM_CH];
    logic [31:0]            speed_q [NUM_CH];
    logic [31:0]            gate_cnt_q;
    logic                   speed_valid_q;
    logic                   bvalid_q, rvalid_q;
    logic [1:0]             bresp_q, rresp_q;
    logic [31:0]            rdata_q;

    logic [31:0]       aw_addr, ar_addr, wr_old, wr_new, rd_val;
    logic [31:0]       reg_view [NUM_CH][4];
    logic [NUM_CH-1:0] wr_sel, wrap, pwm_load, enc_edge;
    logic              rd_hit, wr_fire, rd_fire, gate_term;
    logic              unused_bits;

    function automatic logic [31:0] strobe_merge(input logic [31:0] old_v, input logic [31:0] data,
                                                 input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    assign aw_addr       = 32'(s_axi_awaddr);
    assign ar_addr       = 32'(s_axi_araddr);
    assign wr_fire       = rst_n & s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
    assign rd_fire       = rst_n & s_axi_arvalid & ~rvalid_q;
    assign s_axi_awready = wr_fire;
    assign s_axi_wready  = wr_fire;
    assign s_axi_arready = rd_fire;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign speed_valid   = speed_valid_q;
    assign gate_term     = (gate_cnt_q == GATE_LAST);
    assign wr_new        = strobe_merge(wr_old, s_axi_wdata, s_axi_wstrb);
    assign unused_bits   = ^{aw_addr, ar_addr, wr_new};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_speed
        assign motor_speed[32*g +: 32] = speed_q[g];
    end

    always_comb begin
        wr_sel = '0;
        wr_old = '0;
        rd_hit = 1'b0;
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            reg_view[c][0] = 32'(period_sh_q[c]);
            reg_view[c][1] = 32'(duty_sh_q[c]);
            reg_view[c][2] = {30'b0, ctrl_q[c]};
            reg_view[c][3] = speed_q[c];
            if (aw_addr[31:4] == 28'(c)) begin
                wr_sel[c] = 1'b1;
                wr_old    = reg_view[c][aw_addr[3:2]];
            end
            if (ar_addr[31:4] == 28'(c)) begin
                rd_hit = 1'b1;
                rd_val = reg_view[c][ar_addr[3:2]];
            end
        end
    end

    // Active period/duty follow the shadows while disabled and otherwise only at wrap.
    always_comb begin
        wrap     = '0;
        pwm_load = '0;
        enc_edge = '0;
        pwm_out  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            period_sh_d[c] = period_sh_q[c];
            duty_sh_d[c]   = duty_sh_q[c];
            ctrl_d[c]      = ctrl_q[c];
            if (wr_fire && wr_sel[c]) begin
                case (aw_addr[3:2])
                    2'd0:    period_sh_d[c] = wr_new[CNT_W-1:0];
                    2'd1:    duty_sh_d[c]   = wr_new[CNT_W-1:0];
                    2'd2:    ctrl_d[c]      = wr_new[1:0];
                    default: ;
                endcase
            end
            wrap[c]         = (period_act_q[c] != '0) && (cnt_q[c] == period_act_q[c] - CNT_W'(1));
            pwm_load[c]     = ~ctrl_q[c][0] | wrap[c];
            period_act_d[c] = pwm_load[c] ? period_sh_q[c] : period_act_q[c];
            duty_act_d[c]   = pwm_load[c] ? duty_sh_q[c] : duty_act_q[c];
            cnt_d[c]        = (!ctrl_q[c][0] || period_act_q[c] == '0 || wrap[c]) ? '0
                                                                                   : cnt_q[c] + CNT_W'(1);
            pwm_out[c]      = ctrl_q[c][0] &
                              (((period_act_q[c] != '0) && (cnt_q[c] < duty_act_q[c])) ^ ctrl_q[c][1]);
            enc_edge[c]     = sync_q[c][SYNC_STAGES-1] & ~enc_prev_q[c];
            edge_inc[c]     = (enc_edge[c] && edge_cnt_q[c] != '1) ? edge_cnt_q[c] + 32'd1 : edge_cnt_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                period_sh_q[c]  <= '0;
                duty_sh_q[c]    <= '0;
                period_act_q[c] <= '0;
                duty_act_q[c]   <= '0;
                cnt_q[c]        <= '0;
                ctrl_q[c]       <= '0;
                sync_q[c]       <= '0;
                edge_cnt_q[c]   <= '0;
                speed_q[c]      <= '0;
            end
            enc_prev_q    <= '0;
            gate_cnt_q    <= '0;
            speed_valid_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                period_sh_q[c]  <= period_sh_d[c];
                duty_sh_q[c]    <= duty_sh_d[c];
                period_act_q[c] <= period_act_d[c];
                duty_act_q[c]   <= duty_act_d[c];
                cnt_q[c]        <= cnt_d[c];
                ctrl_q[c]       <= ctrl_d[c];
                sync_q[c]       <= {sync_q[c][SYNC_STAGES-2:0], encoder_signal[c]};
                enc_prev_q[c]   <= sync_q[c][SYNC_STAGES-1];
                if (gate_term) begin
                    speed_q[c]    <= edge_inc[c];
                    edge_cnt_q[c] <= '0;
                end else begin
                    edge_cnt_q[c] <= edge_inc[c];
                end
            end
            gate_cnt_q    <= gate_term ? '0 : gate_cnt_q + 32'd1;
            speed_valid_q <= gate_term;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_hit ? rd_val : 32'd0;
                rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule
